// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm ring controller.
// State codes and BCD field positions of the 24-bit time word.
package alarm_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] RINGING  = 2'd2;
  localparam logic [1:0] SNOOZING = 2'd3;

  localparam int HR_MSB  = 23;
  localparam int MIN_LSB = 8;
  localparam int SEC_MSB = 7;
  localparam int SEC_LSB = 0;

  localparam int CNT_W = 9;

  // Alarm seconds are ignored; clock must sit on :00.
  function automatic logic time_match(
    input logic [23:0] ct,
    input logic [23:0] at
  );
    return (ct[HR_MSB:MIN_LSB] == at[HR_MSB:MIN_LSB])
        && (ct[SEC_MSB:SEC_LSB] == 8'h00);
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Time/alarm comparator with rising-edge detect.
// The history register runs in every state.
module alarm_match
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] clock_time,
  input  logic [23:0] alarm_time,
  output logic        match_rise
);

  logic match;
  logic match_q;

  assign match = time_match(clock_time, alarm_time);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign match_rise = match & ~match_q;

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm ring/snooze/dismiss sequencer driving the speaker gate.
// Advanced by the second tick and debounced button pulses.
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sec_tick,
  input  logic [23:0] clock_time,
  input  logic [23:0] alarm_time,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        play,
  output logic [1:0]  state
);

  localparam logic [CNT_W-1:0] RING_LAST =
    CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNZ_LOAD =
    CNT_W'(SNOOZE_S - 1);

  logic             match_rise;
  logic [CNT_W-1:0] ring_cnt;
  logic [CNT_W-1:0] snz_cnt;

  alarm_match u_match (
    .clk        (clk),
    .rst        (rst),
    .clock_time (clock_time),
    .alarm_time (alarm_time),
    .match_rise (match_rise)
  );

  // play is registered alongside state so it equals (state == RINGING).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      play     <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else if (!enable) begin
      state <= IDLE;
      play  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= ARMED;
          play  <= 1'b0;
        end
        ARMED: begin
          if (match_rise) begin
            state    <= RINGING;
            play     <= 1'b1;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state <= ARMED;
            play  <= 1'b0;
          end else if (snooze) begin
            state   <= SNOOZING;
            play    <= 1'b0;
            snz_cnt <= SNZ_LOAD;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state <= ARMED;
              play  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
        SNOOZING: begin
          if (dismiss) begin
            state <= ARMED;
            play  <= 1'b0;
          end else if (sec_tick) begin
            if (snz_cnt == '0) begin
              state    <= RINGING;
              play     <= 1'b1;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          play  <= 1'b0;
        end
      endcase
    end
  end

endmodule
